maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
- FSM that sequences the mouse-location datapath through a depth-first search of a 16x16 maze, from location 8'h00 to a goal cell.
- Reads wall bits from and writes visited marks to a 256x1 maze memory.
- Drives datapath moves (adderEn/rgLd), push on advance, and pop on backtrack.
- On reaching the goal, raises done and then holds run while the datapath stack replays the path.

Parameters:
- GOAL, 8'hFF, target location {X[7:4], Y[3:0]}.
- MAX_CYC, 16'd8192, watchdog cycle limit per search. Exceeding it forces FAIL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle request to begin a search. Accepted only in IDLE.
- cntReach  in  1  from datapath. 1 means the move in the current dir would cross the maze edge.
- empStck  in  1  from datapath. Stack empty.
- curLoc  in  8  from datapath. Current location.
- nxtLoc  in  8  from datapath. Location the datapath would load next.
- memDout  in  1  maze memory read data. 1 = wall or visited. Valid one cycle after memRd.
- rgLd  out  1  datapath location-register load.
- dir  out  2  move direction: 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1.
- adderEn  out  1  datapath adder enable (nxtLoc = neighbour).
- push  out  1  push curLoc to the stack.
- pop  out  1  pop the stack into nxtLoc.
- done  out  1  one-cycle pulse when the goal is reached.
- run  out  1  high during stack replay.
- memAddr  out  8  maze memory address.
- memRd  out  1  maze memory read strobe.
- memWr  out  1  maze memory write strobe. Write data is constant 1.
- busy  out  1  high in every state except IDLE.
- fail  out  1  sticky. High if no path exists or the watchdog expires. Cleared by the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, dir=00, watchdog=0. All outputs 0, including fail.
- Outputs are Moore-decoded from registered state/dir. cntReach and memDout are sampled in the states named below.
- IDLE: start=1 -> MARK; clear fail and watchdog. Otherwise stay.
- MARK: memWr=1, memAddr=curLoc -> CHKGOAL.
- CHKGOAL: curLoc==GOAL -> DONE; otherwise dir<=00 -> DIRSEL.
- DIRSEL: adderEn=1.
  - cntReach=1 -> NEXTDIR.
  - Otherwise memRd=1, memAddr=nxtLoc -> EVAL.
- EVAL: adderEn=1, memAddr=nxtLoc.
  - memDout=1 -> NEXTDIR.
  - memDout=0 -> MOVE.
- MOVE: adderEn=1, push=1, rgLd=1 in the same cycle. The stack captures the old curLoc; the register loads the neighbour. -> MARK.
- NEXTDIR:
  - dir==11 -> BACK.
  - Otherwise dir<=dir+1 -> DIRSEL.
- BACK:
  - empStck=1 -> FAIL.
  - Otherwise pop=1, rgLd=1 (curLoc <= popped location), dir<=00 -> DIRSEL. No re-mark; the cell is already visited.
- DONE: done=1 for one cycle -> RUN.
- RUN: run=1 until empStck=1 is sampled, then -> IDLE.
- FAIL: fail<=1 -> IDLE.
- adderEn is never asserted in the same cycle as pop. push and pop are never asserted in the same cycle.
- Latency per successful step is 5 cycles: DIRSEL, EVAL, MOVE, MARK, CHKGOAL. Each rejected direction costs 2 cycles (via cntReach) or 3 cycles (via wall).
- Watchdog:
  - Increments every cycle while busy and not in RUN.
  - Reaching MAX_CYC in any search state forces FAIL on the next edge. Memory strobes are deasserted in that cycle.
- The start cell 8'h00 is marked in the first MARK. A GOAL of 8'h00 yields done 2 cycles after start (MARK, CHKGOAL, then DONE).
- start while busy is ignored.
- Reset mid-operation returns to IDLE immediately. Maze memory contents are not restored by this block.

Test Plan:
1. Open maze (all memDout=0), GOAL=8'hFF, start -> search reaches 8'hFF with done pulsed exactly once. push count == number of moves; no pop occurs. run stays high until empStck, then busy=0.
2. Location 8'h00 with dir=00 and dir=10 -> cntReach=1; the controller skips to the next dir with no memRd issued. Location 8'hF0 with dir=01 -> likewise skipped.
3. Dead-end corridor: from 8'h00, only 8'h10 is open and all its other neighbours are walls -> exactly one MOVE, then BACK pops to 8'h00, then DIRSEL restarts at dir=00. Final result is fail=1 with empStck=1.
4. Goal fully walled (8'hEF and 8'hFE set to 1) -> fail=1, done never asserted. busy returns to 0, and a new start clears fail.
5. MAX_CYC=16 with an open maze -> fail=1 on the cycle after the watchdog reaches 16; no done.
6. rst=0 asserted during MOVE (asynchronous, mid-cycle) -> all outputs go to 0 immediately and state=IDLE. After release, start restarts the search cleanly.

Source files
------------

// File: rtl/maze_solver_ctrl.sv
// Depth-first search sequencer for a 16x16 maze: walks the mouse-location
// datapath from 8'h00 to GOAL, marking visited cells and backtracking via the stack.
module maze_solver_ctrl #(
    parameter logic [7:0]  GOAL    = 8'hFF,
    parameter logic [15:0] MAX_CYC = 16'd8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cntReach,
    input  logic       empStck,
    input  logic [7:0] curLoc,
    input  logic [7:0] nxtLoc,
    input  logic       memDout,
    output logic       rgLd,
    output logic [1:0] dir,
    output logic       adderEn,
    output logic       push,
    output logic       pop,
    output logic       done,
    output logic       run,
    output logic [7:0] memAddr,
    output logic       memRd,
    output logic       memWr,
    output logic       busy,
    output logic       fail
);

    localparam int unsigned WD_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MARK,
        S_CHKGOAL,
        S_DIRSEL,
        S_EVAL,
        S_MOVE,
        S_NEXTDIR,
        S_BACK,
        S_DONE,
        S_RUN,
        S_FAIL
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dir_q, dir_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            fail_q, fail_d;
    logic            search_c;
    logic            wd_hit_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= 2'b00;
            wdog_q  <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wdog_q  <= wdog_d;
            fail_q  <= fail_d;
        end
    end

    // Watchdog only polices the exploring states, not DONE/RUN/FAIL.
    assign search_c = state_q inside {S_MARK, S_CHKGOAL, S_DIRSEL, S_EVAL,
                                      S_MOVE, S_NEXTDIR, S_BACK};
    assign wd_hit_c = search_c && (wdog_q >= MAX_CYC);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        wdog_d  = wdog_q;
        fail_d  = fail_q;
        rgLd    = 1'b0;
        adderEn = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        done    = 1'b0;
        run     = 1'b0;
        memAddr = 8'h00;
        memRd   = 1'b0;
        memWr   = 1'b0;

        // Saturating count so a long DONE/FAIL dwell cannot wrap it.
        if ((state_q != S_IDLE) && (state_q != S_RUN) && (wdog_q < MAX_CYC)) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MARK;
                    fail_d  = 1'b0;
                    wdog_d  = '0;
                end
            end
            S_MARK: begin
                memWr   = 1'b1;
                memAddr = curLoc;
                state_d = S_CHKGOAL;
            end
            S_CHKGOAL: begin
                if (curLoc == GOAL) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = 2'b00;
                    state_d = S_DIRSEL;
                end
            end
            S_DIRSEL: begin
                adderEn = 1'b1;
                if (cntReach) begin
                    state_d = S_NEXTDIR;
                end else begin
                    memRd   = 1'b1;
                    memAddr = nxtLoc;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                adderEn = 1'b1;
                memAddr = nxtLoc;
                state_d = memDout ? S_NEXTDIR : S_MOVE;
            end
            S_MOVE: begin
                adderEn = 1'b1;
                push    = 1'b1;
                rgLd    = 1'b1;
                state_d = S_MARK;
            end
            S_NEXTDIR: begin
                if (dir_q == 2'b11) begin
                    state_d = S_BACK;
                end else begin
                    dir_d   = dir_q + 2'd1;
                    state_d = S_DIRSEL;
                end
            end
            S_BACK: begin
                if (empStck) begin
                    state_d = S_FAIL;
                end else begin
                    pop     = 1'b1;
                    rgLd    = 1'b1;
                    dir_d   = 2'b00;
                    state_d = S_DIRSEL;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                run = 1'b1;
                if (empStck) begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wd_hit_c) begin
            state_d = S_FAIL;
            memRd   = 1'b0;
            memWr   = 1'b0;
        end

        // fail rises together with entry into FAIL and stays until the next start.
        if (state_d == S_FAIL) begin
            fail_d = 1'b1;
        end
    end

    assign dir  = dir_q;
    assign busy = (state_q != S_IDLE);
    assign fail = fail_q;

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Directed bench for maze_solver_ctrl: a behavioural datapath/stack/maze-memory
// model closes the loop around two controller instances (default and short watchdog).
module tb_maze_solver_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, sel, clr;
    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic [7:0] cur_loc, nxt_loc, nb;
    logic       cnt_reach, emp_stck, mem_dout;

    logic       a_rgLd, a_adderEn, a_push, a_pop, a_done, a_run, a_memRd, a_memWr, a_busy, a_fail;
    logic [1:0] a_dir;
    logic [7:0] a_memAddr;
    logic       b_rgLd, b_adderEn, b_push, b_pop, b_done, b_run, b_memRd, b_memWr, b_busy, b_fail;
    logic [1:0] b_dir;
    logic [7:0] b_memAddr;

    maze_solver_ctrl u_a (
        .clk(clk), .rst(rst), .start(start_a), .cntReach(cnt_reach), .empStck(emp_stck),
        .curLoc(cur_loc), .nxtLoc(nxt_loc), .memDout(mem_dout), .rgLd(a_rgLd), .dir(a_dir),
        .adderEn(a_adderEn), .push(a_push), .pop(a_pop), .done(a_done), .run(a_run),
        .memAddr(a_memAddr), .memRd(a_memRd), .memWr(a_memWr), .busy(a_busy), .fail(a_fail)
    );

    maze_solver_ctrl #(.MAX_CYC(16'd16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .cntReach(cnt_reach), .empStck(emp_stck),
        .curLoc(cur_loc), .nxtLoc(nxt_loc), .memDout(mem_dout), .rgLd(b_rgLd), .dir(b_dir),
        .adderEn(b_adderEn), .push(b_push), .pop(b_pop), .done(b_done), .run(b_run),
        .memAddr(b_memAddr), .memRd(b_memRd), .memWr(b_memWr), .busy(b_busy), .fail(b_fail)
    );

    // Selected controller drives the shared datapath model.
    logic       d_rgLd, d_adderEn, d_push, d_pop, d_done, d_run, d_memRd, d_memWr, d_busy, d_fail;
    logic [1:0] d_dir;
    logic [7:0] d_memAddr;
    assign d_rgLd    = sel ? b_rgLd    : a_rgLd;
    assign d_adderEn = sel ? b_adderEn : a_adderEn;
    assign d_push    = sel ? b_push    : a_push;
    assign d_pop     = sel ? b_pop     : a_pop;
    assign d_done    = sel ? b_done    : a_done;
    assign d_run     = sel ? b_run     : a_run;
    assign d_memRd   = sel ? b_memRd   : a_memRd;
    assign d_memWr   = sel ? b_memWr   : a_memWr;
    assign d_busy    = sel ? b_busy    : a_busy;
    assign d_fail    = sel ? b_fail    : a_fail;
    assign d_dir     = sel ? b_dir     : a_dir;
    assign d_memAddr = sel ? b_memAddr : a_memAddr;

    logic [19:0] a_vec, b_vec;
    logic [15:0] d_obs;
    assign a_vec = {a_rgLd, a_dir, a_adderEn, a_push, a_pop, a_done, a_run, a_memAddr,
                    a_memRd, a_memWr, a_busy, a_fail};
    assign b_vec = {b_rgLd, b_dir, b_adderEn, b_push, b_pop, b_done, b_run, b_memAddr,
                    b_memRd, b_memWr, b_busy, b_fail};
    assign d_obs = {d_rgLd, d_adderEn, d_push, d_pop, d_memRd, d_memWr, d_dir, d_memAddr};

    // Datapath model: location register, adder, stack, maze memory.
    logic [7:0] stk [256];
    logic       wall [256];
    logic       vis  [256];
    int         sp;

    always_comb begin
        case (d_dir)
            2'd0:    begin cnt_reach = (cur_loc[3:0] == 4'h0); nb = {cur_loc[7:4], cur_loc[3:0] - 4'd1}; end
            2'd1:    begin cnt_reach = (cur_loc[7:4] == 4'hF); nb = {cur_loc[7:4] + 4'd1, cur_loc[3:0]}; end
            2'd2:    begin cnt_reach = (cur_loc[7:4] == 4'h0); nb = {cur_loc[7:4] - 4'd1, cur_loc[3:0]}; end
            default: begin cnt_reach = (cur_loc[3:0] == 4'hF); nb = {cur_loc[7:4], cur_loc[3:0] + 4'd1}; end
        endcase
        nxt_loc  = (d_pop && sp > 0) ? stk[8'(sp - 1)] : nb;
        emp_stck = (sp == 0);
    end

    always @(posedge clk) begin
        if (clr) begin
            sp       <= 0;
            cur_loc  <= 8'h00;
            mem_dout <= 1'b0;
            for (int i = 0; i < 256; i++) vis[i] <= 1'b0;
        end else begin
            if (d_rgLd) cur_loc <= nxt_loc;
            if (d_push) begin
                stk[8'(sp)] <= cur_loc;
                sp <= sp + 1;
            end else if ((d_pop || d_run) && sp > 0) begin
                sp <= sp - 1;
            end
            if (d_memWr) vis[d_memAddr] <= 1'b1;
            if (d_memRd) mem_dout <= wall[d_memAddr] | vis[d_memAddr];
        end
    end

    // Event monitor sampled on the falling edge.
    int         n_push, n_pop, n_done, n_run, n_busy, n_rd_edge, n_bad_pair;
    logic       seen_00_d0, seen_00_d2, seen_f0_d1, prev_pop;
    logic [1:0] ap_dir;
    logic [7:0] ap_loc;

    always @(negedge clk) begin
        if (clr) begin
            n_push <= 0; n_pop <= 0; n_done <= 0; n_run <= 0; n_busy <= 0;
            n_rd_edge <= 0; n_bad_pair <= 0;
            seen_00_d0 <= 1'b0; seen_00_d2 <= 1'b0; seen_f0_d1 <= 1'b0; prev_pop <= 1'b0;
            ap_dir <= 2'b11; ap_loc <= 8'hAA;
        end else begin
            if (d_push) n_push <= n_push + 1;
            if (d_pop)  n_pop  <= n_pop + 1;
            if (d_done) n_done <= n_done + 1;
            if (d_run)  n_run  <= n_run + 1;
            if (d_busy) n_busy <= n_busy + 1;
            if (d_adderEn && cnt_reach && d_memRd) n_rd_edge <= n_rd_edge + 1;
            if ((d_adderEn && d_pop) || (d_push && d_pop)) n_bad_pair <= n_bad_pair + 1;
            if (d_adderEn && cnt_reach && !d_memRd) begin
                if (cur_loc == 8'h00 && d_dir == 2'd0) seen_00_d0 <= 1'b1;
                if (cur_loc == 8'h00 && d_dir == 2'd2) seen_00_d2 <= 1'b1;
                if (cur_loc == 8'hF0 && d_dir == 2'd1) seen_f0_d1 <= 1'b1;
            end
            if (prev_pop) begin
                ap_dir <= d_dir;
                ap_loc <= cur_loc;
            end
            prev_pop <= d_pop;
        end
    end

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic set_walls(input logic v);
        for (int i = 0; i < 256; i++) wall[i] = v;
    endtask

    task automatic dp_clear();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Returns at the falling edge of the first search cycle (MARK).
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!d_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; sel = 1'b0; clr = 1'b1;
        set_walls(1'b0);
        repeat (2) @(negedge clk);
        chk_cnt++; if (a_vec !== 20'h0) begin err_cnt++; $display("FAIL reset_a_outputs: got %h want 0", a_vec); end
        chk_cnt++; if (b_vec !== 20'h0) begin err_cnt++; $display("FAIL reset_b_outputs: got %h want 0", b_vec); end
        rst = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (a_vec !== 20'h0) begin err_cnt++; $display("FAIL idle_after_reset: got %h want 0", a_vec); end
    endtask

    task automatic test_open_maze();
        logic [15:0] exp_obs [8];
        bit ok;
        exp_obs = '{16'h0400, 16'h0000, 16'h4000, 16'h0000, 16'h4910, 16'h4110, 16'hE100, 16'h0510};
        sel = 1'b0;
        set_walls(1'b0);
        dp_clear();
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk_cnt++;
            if (d_obs !== exp_obs[k]) begin
                err_cnt++;
                $display("FAIL open_step%0d: got %h want %h", k, d_obs, exp_obs[k]);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (d_done) begin ok = 1'b1; break; end
        end
        chk_cnt++; if (!ok) begin err_cnt++; $display("FAIL open_done_timeout: got no done want done"); end
        chk_cnt++; if (cur_loc !== 8'hFF) begin err_cnt++; $display("FAIL open_done_loc: got %h want ff", cur_loc); end
        wait_idle(1000, ok);
        chk_cnt++; if (!ok) begin err_cnt++; $display("FAIL open_idle_timeout: got busy want idle"); end
        chk_cnt++; if (n_push !== 240) begin err_cnt++; $display("FAIL open_push_cnt: got %0d want 240", n_push); end
        chk_cnt++; if (n_pop !== 0) begin err_cnt++; $display("FAIL open_pop_cnt: got %0d want 0", n_pop); end
        chk_cnt++; if (n_done !== 1) begin err_cnt++; $display("FAIL open_done_cnt: got %0d want 1", n_done); end
        chk_cnt++; if (n_run !== 241) begin err_cnt++; $display("FAIL open_run_cycles: got %0d want 241", n_run); end
        chk_cnt++; if (d_fail !== 1'b0) begin err_cnt++; $display("FAIL open_fail: got %b want 0", d_fail); end
        chk_cnt++; if (n_rd_edge !== 0) begin err_cnt++; $display("FAIL open_rd_on_edge: got %0d want 0", n_rd_edge); end
        chk_cnt++; if ({seen_00_d0, seen_f0_d1} !== 2'b11) begin err_cnt++; $display("FAIL open_edge_skips: got %b want 11", {seen_00_d0, seen_f0_d1}); end
        chk_cnt++; if (n_bad_pair !== 0) begin err_cnt++; $display("FAIL open_strobe_pair: got %0d want 0", n_bad_pair); end
    endtask

    task automatic test_dead_end();
        bit ok;
        sel = 1'b0;
        set_walls(1'b1);
        wall[8'h00] = 1'b0;
        wall[8'h10] = 1'b0;
        dp_clear();
        pulse_start();
        wait_idle(200, ok);
        chk_cnt++; if (!ok) begin err_cnt++; $display("FAIL dead_idle_timeout: got busy want idle"); end
        chk_cnt++; if (n_busy !== 33) begin err_cnt++; $display("FAIL dead_busy_cycles: got %0d want 33", n_busy); end
        chk_cnt++; if (n_push !== 1) begin err_cnt++; $display("FAIL dead_push_cnt: got %0d want 1", n_push); end
        chk_cnt++; if (n_pop !== 1) begin err_cnt++; $display("FAIL dead_pop_cnt: got %0d want 1", n_pop); end
        chk_cnt++; if ({ap_dir, ap_loc} !== 10'h000) begin err_cnt++; $display("FAIL dead_after_pop: got dir=%b loc=%h want dir=00 loc=00", ap_dir, ap_loc); end
        chk_cnt++; if (d_fail !== 1'b1) begin err_cnt++; $display("FAIL dead_fail: got %b want 1", d_fail); end
        chk_cnt++; if (n_done !== 0) begin err_cnt++; $display("FAIL dead_done_cnt: got %0d want 0", n_done); end
        chk_cnt++; if (emp_stck !== 1'b1) begin err_cnt++; $display("FAIL dead_empty: got %b want 1", emp_stck); end
        chk_cnt++; if (seen_00_d2 !== 1'b1) begin err_cnt++; $display("FAIL dead_edge_x_minus: got %b want 1", seen_00_d2); end
        chk_cnt++; if (n_bad_pair !== 0) begin err_cnt++; $display("FAIL dead_strobe_pair: got %0d want 0", n_bad_pair); end
    endtask

    task automatic test_goal_walled();
        bit ok;
        sel = 1'b0;
        set_walls(1'b0);
        wall[8'hEF] = 1'b1;
        wall[8'hFE] = 1'b1;
        dp_clear();
        pulse_start();
        wait_idle(20000, ok);
        chk_cnt++; if (!ok) begin err_cnt++; $display("FAIL walled_idle_timeout: got busy want idle"); end
        chk_cnt++; if (d_fail !== 1'b1) begin err_cnt++; $display("FAIL walled_fail: got %b want 1", d_fail); end
        chk_cnt++; if (n_done !== 0) begin err_cnt++; $display("FAIL walled_done_cnt: got %0d want 0", n_done); end
        set_walls(1'b0);
        dp_clear();
        pulse_start();
        chk_cnt++; if ({d_fail, d_busy} !== 2'b01) begin err_cnt++; $display("FAIL restart_clears_fail: got fail,busy=%b want 01", {d_fail, d_busy}); end
        wait_idle(5000, ok);
        chk_cnt++; if (!ok || n_done !== 1) begin err_cnt++; $display("FAIL restart_done: got idle=%b done=%0d want idle=1 done=1", ok, n_done); end
    endtask

    task automatic test_watchdog();
        sel = 1'b1;
        set_walls(1'b0);
        dp_clear();
        pulse_start();
        repeat (16) @(negedge clk);
        chk_cnt++; if ({d_fail, d_busy, d_memRd, d_memWr} !== 4'b0100) begin err_cnt++; $display("FAIL wd_limit_cycle: got fail,busy,rd,wr=%b want 0100", {d_fail, d_busy, d_memRd, d_memWr}); end
        @(negedge clk);
        chk_cnt++; if ({d_fail, d_busy} !== 2'b11) begin err_cnt++; $display("FAIL wd_fail_rise: got fail,busy=%b want 11", {d_fail, d_busy}); end
        @(negedge clk);
        chk_cnt++; if ({d_fail, d_busy} !== 2'b10) begin err_cnt++; $display("FAIL wd_back_idle: got fail,busy=%b want 10", {d_fail, d_busy}); end
        chk_cnt++; if (n_done !== 0) begin err_cnt++; $display("FAIL wd_done_cnt: got %0d want 0", n_done); end
        chk_cnt++; if (n_push !== 2) begin err_cnt++; $display("FAIL wd_push_cnt: got %0d want 2", n_push); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        bit ok;
        sel = 1'b0;
        set_walls(1'b0);
        dp_clear();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (d_push) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk_cnt++; if (!ok) begin err_cnt++; $display("FAIL rstmove_reach_move: got no push want push"); end
        #2 rst = 1'b0;
        #1;
        chk_cnt++; if (a_vec !== 20'h0) begin err_cnt++; $display("FAIL rstmove_outputs: got %h want 0", a_vec); end
        @(negedge clk);
        chk_cnt++; if (a_vec !== 20'h0) begin err_cnt++; $display("FAIL rstmove_hold: got %h want 0", a_vec); end
        rst = 1'b1;
        dp_clear();
        pulse_start();
        chk_cnt++; if ({d_busy, d_obs} !== {1'b1, 16'h0400}) begin err_cnt++; $display("FAIL rstmove_restart: got busy=%b obs=%h want busy=1 obs=0400", d_busy, d_obs); end
        wait_idle(5000, ok);
        chk_cnt++; if (!ok || n_done !== 1 || d_fail !== 1'b0) begin err_cnt++; $display("FAIL rstmove_complete: got idle=%b done=%0d fail=%b want 1 1 0", ok, n_done, d_fail); end
    endtask

    initial begin
        test_reset();
        test_open_maze();
        test_dead_end();
        test_goal_walled();
        test_watchdog();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
